// File: rtl/complex_mul_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// complex_mul_issue_ctrl_if
//   Bundles the three streams handled by complex_mul_issue_ctrl:
//     in_*   operand-pair request stream (valid/ready) with request tag
//     mul_*  enable/operands to the pipelined complex multiplier, and its
//            result/valid coming back (fixed latency, no backpressure)
//     out_*  show-ahead result stream (valid/ready) with the returned tag
//   master : the issue controller (accepts in_*, drives mul_* and out_*)
//   slave  : the surrounding logic (request source, multiplier, consumer)
// ---------------------------------------------------------------------------
interface complex_mul_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a_real;
  logic [31:0]      in_a_imag;
  logic [31:0]      in_c_real;
  logic [31:0]      in_c_imag;
  logic [TAG_W-1:0] in_tag;

  logic             mul_enable;
  logic [31:0]      mul_a_real;
  logic [31:0]      mul_a_imag;
  logic [31:0]      mul_c_real;
  logic [31:0]      mul_c_imag;
  logic [31:0]      mul_re;
  logic [31:0]      mul_im;
  logic             mul_valid;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_re;
  logic [31:0]      out_im;
  logic [TAG_W-1:0] out_tag;

  modport master (
    input  in_valid, in_a_real, in_a_imag, in_c_real, in_c_imag, in_tag,
    output in_ready,
    output mul_enable, mul_a_real, mul_a_imag, mul_c_real, mul_c_imag,
    input  mul_re, mul_im, mul_valid,
    output out_valid, out_re, out_im, out_tag,
    input  out_ready
  );

  modport slave (
    output in_valid, in_a_real, in_a_imag, in_c_real, in_c_imag, in_tag,
    input  in_ready,
    input  mul_enable, mul_a_real, mul_a_imag, mul_c_real, mul_c_imag,
    output mul_re, mul_im, mul_valid,
    input  out_valid, out_re, out_im, out_tag,
    output out_ready
  );
endinterface

// File: rtl/complex_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// complex_mul_issue_ctrl
//   Issue/collect controller for a fixed-latency pipelined complex multiplier.
//   A request is accepted only when a result-FIFO slot is guaranteed for it
//   (buffered results + in-flight requests < DEPTH), so a returning result can
//   always be pushed without backpressure. The request tag rides a MUL_LAT-deep
//   shift register alongside the multiplier and is re-joined with the result.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          complex_mul_issue_ctrl_if.master (in_*, mul_*, out_* streams)
//   inflight     requests issued whose result has not yet returned
//   err_spurious sticky flag: mul_valid arrived with nothing in flight
// ---------------------------------------------------------------------------
module complex_mul_issue_ctrl #(
  parameter int MUL_LAT = 7,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  complex_mul_issue_ctrl_if.master bus,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err_spurious
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      re;
    logic [31:0]      im;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [TAG_W-1:0] tag_line_q [MUL_LAT];
  logic [TAG_W-1:0] tag_line_d [MUL_LAT];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  entry_t           mem_q [DEPTH];

  logic             ready;
  logic             issue;
  logic             push;
  logic             pop;
  logic [CW:0]      credit_used;

  // Credit check uses only registered counts: a slot freed by a pop this cycle
  // becomes available next cycle, keeping in_ready off any combinational path
  // from out_ready or mul_valid.
  assign credit_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign ready       = !rst && (credit_used < DEPTH[CW:0]);
  assign issue       = bus.in_valid && ready;
  // A result with nothing in flight is spurious: flagged, never buffered.
  assign push        = bus.mul_valid && (inflight_q != '0);
  assign pop         = out_valid_q && bus.out_ready;

  assign bus.in_ready   = ready;
  assign bus.mul_enable = issue;
  assign bus.mul_a_real = bus.in_a_real;
  assign bus.mul_a_imag = bus.in_a_imag;
  assign bus.mul_c_real = bus.in_c_real;
  assign bus.mul_c_imag = bus.in_c_imag;

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = mem_q[rd_ptr_q].re;
  assign bus.out_im    = mem_q[rd_ptr_q].im;
  assign bus.out_tag   = mem_q[rd_ptr_q].tag;

  assign inflight     = inflight_q;
  assign err_spurious = err_q;

  always_comb begin
    // NOTE: every _d starts from its held value so no branch can infer a latch.
    tag_line_d   = tag_line_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    inflight_d   = inflight_q;

    // Stage 0 carries a tag only in issue cycles; stage MUL_LAT-1 lines up
    // with the multiplier's mul_valid for the same request.
    tag_line_d[0] = issue ? bus.in_tag : '0;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_line_d[i] = tag_line_q[i-1];
    end

    if (issue && !push) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue && push) begin
      inflight_d = inflight_q - CW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CW'(1);
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CW'(1);
    end

    out_valid_d = (fifo_count_d != '0);
    err_d       = err_q || (bus.mul_valid && (inflight_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_line_q   <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      inflight_q   <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tag_line_q   <= tag_line_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      inflight_q   <= inflight_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; out_valid_q and the
  // pointers/count decide what is visible, so stale entries are never exposed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{re: bus.mul_re, im: bus.mul_im, tag: tag_line_q[MUL_LAT-1]};
    end
  end

endmodule

// File: tb/tb_complex_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_complex_mul_issue_ctrl
//   Drives complex_mul_issue_ctrl with directed and $urandom traffic. A simple
//   integer-valued FP32 multiplier stand-in closes the loop. The reference
//   model is a queue of requests that have been issued but not yet consumed,
//   each stamped with its issue cycle; readiness, output timing, in-flight
//   count and expected results are all derived from that queue.
// ---------------------------------------------------------------------------
module tb_complex_mul_issue_ctrl;

  localparam int MUL_LAT = 7;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  complex_mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();
  logic [$clog2(DEPTH):0] inflight;
  logic                   err_spurious;

  complex_mul_issue_ctrl #(
    .MUL_LAT(MUL_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inflight     (inflight),
    .err_spurious (err_spurious)
  );

  // ---------------- FP32 helpers (integer-valued operands only) -----------
  function automatic logic [31:0] int_to_fp32(int n);
    int          mag;
    int          p;
    logic [31:0] r;
    if (n == 0) return 32'h0;
    mag = (n < 0) ? -n : n;
    p = 0;
    for (int i = 0; i < 31; i++) if ((mag >> i) != 0) p = i;
    r[31]    = (n < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(mag << (23 - p));
    return r;
  endfunction

  function automatic int fp32_to_int(logic [31:0] b);
    int e;
    int m;
    if (b[30:0] == 31'h0) return 0;
    e = int'(b[30:23]) - 127;
    m = int'({1'b1, b[22:0]}) >> (23 - e);
    return b[31] ? -m : m;
  endfunction

  // ---------------- multiplier stand-in (flushed by rst) ------------------
  logic        mp_v  [MUL_LAT] = '{default: 1'b0};
  logic [31:0] mp_re [MUL_LAT];
  logic [31:0] mp_im [MUL_LAT];
  logic        spur = 1'b0;

  always @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      mp_v[i]  <= mp_v[i-1];
      mp_re[i] <= mp_re[i-1];
      mp_im[i] <= mp_im[i-1];
    end
    mp_v[0]  <= bus.mul_enable;
    mp_re[0] <= int_to_fp32(fp32_to_int(bus.mul_a_real) * fp32_to_int(bus.mul_c_real)
                          - fp32_to_int(bus.mul_a_imag) * fp32_to_int(bus.mul_c_imag));
    mp_im[0] <= int_to_fp32(fp32_to_int(bus.mul_a_real) * fp32_to_int(bus.mul_c_imag)
                          + fp32_to_int(bus.mul_a_imag) * fp32_to_int(bus.mul_c_real));
    if (rst) for (int i = 0; i < MUL_LAT; i++) mp_v[i] <= 1'b0;
  end

  assign bus.mul_valid = mp_v[MUL_LAT-1] | spur;
  assign bus.mul_re    = mp_re[MUL_LAT-1];
  assign bus.mul_im    = mp_im[MUL_LAT-1];

  // ---------------- reference model & bookkeeping ------------------------
  typedef struct {
    int         ar, ai, cr, ci;
    logic [3:0] tag;
    int         issue_cyc;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  bit    err_exp = 1'b0;
  bit    last_iss;
  int    cur_ar, cur_ai, cur_cr, cur_ci;
  int    n_chk = 0, n_pass = 0;
  int    n_en = 0, n_pop = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(int ar, int ai, int cr, int ci, logic [3:0] tag);
    cur_ar = ar; cur_ai = ai; cur_cr = cr; cur_ci = ci;
    bus.in_a_real = int_to_fp32(ar);
    bus.in_a_imag = int_to_fp32(ai);
    bus.in_c_real = int_to_fp32(cr);
    bus.in_c_imag = int_to_fp32(ci);
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
  endtask

  task automatic rand_req(logic [3:0] tag);
    set_req(int'($urandom_range(0, 128)) - 64, int'($urandom_range(0, 128)) - 64,
            int'($urandom_range(0, 128)) - 64, int'($urandom_range(0, 128)) - 64, tag);
  endtask

  // One clock cycle: check all DUT outputs against the model at the falling
  // edge, advance the model for the coming rising edge, then step past it.
  task automatic step();
    int    inflight_exp;
    bit    rdy_exp, ov_exp, iss;
    item_t it;
    @(negedge clk);
    rdy_exp = !rst && (q.size() < DEPTH);
    iss     = bus.in_valid && rdy_exp;
    inflight_exp = 0;
    foreach (q[i]) if (q[i].issue_cyc + MUL_LAT >= cyc) inflight_exp++;
    ov_exp = (q.size() > 0) && (cyc > q[0].issue_cyc + MUL_LAT);

    check("in_ready", bus.in_ready, rdy_exp);
    check("mul_enable", bus.mul_enable, iss);
    if (iss) begin
      check("mul_a_real", bus.mul_a_real, int_to_fp32(cur_ar));
      check("mul_a_imag", bus.mul_a_imag, int_to_fp32(cur_ai));
      check("mul_c_real", bus.mul_c_real, int_to_fp32(cur_cr));
      check("mul_c_imag", bus.mul_c_imag, int_to_fp32(cur_ci));
    end
    check("out_valid", bus.out_valid, ov_exp);
    if (ov_exp) begin
      check("out_re", bus.out_re, int_to_fp32(q[0].ar * q[0].cr - q[0].ai * q[0].ci));
      check("out_im", bus.out_im, int_to_fp32(q[0].ar * q[0].ci + q[0].ai * q[0].cr));
      check("out_tag", bus.out_tag, q[0].tag);
    end
    check("inflight", inflight, inflight_exp);
    check("err_spurious", err_spurious, err_exp);
    if (bus.mul_enable) n_en++;
    if (bus.out_valid && bus.out_ready) n_pop++;

    if (rst) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      if (spur && inflight_exp == 0) err_exp = 1'b1;
      if (ov_exp && bus.out_ready) void'(q.pop_front());
      if (iss) begin
        it = '{ar: cur_ar, ai: cur_ai, cr: cur_cr, ci: cur_ci, tag: bus.in_tag, issue_cyc: cyc};
        q.push_back(it);
      end
    end
    last_iss = iss;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Hold the current request until it is issued (bounded).
  task automatic offer();
    int n = 0;
    do begin
      step();
      n++;
    end while (!last_iss && n < 60);
    check("offer_accepted", last_iss, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() > 0; i++) step();
    step();
    check("drain_out_valid", bus.out_valid, 1'b0);
    check("drain_inflight", inflight, 0);
  endtask

  // ---------------- directed sequence ------------------------------------
  initial begin
    int c0, en0, pop0;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_req(0, 0, 0, 0, 4'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_mul_enable", bus.mul_enable, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err_spurious, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    // T1: (1+j2)*(3+j4) = -5+j10, result one cycle after mul_valid
    bus.out_ready = 1'b1;
    set_req(1, 2, 3, 4, 4'd5);
    c0 = cyc;
    offer();
    for (int i = 0; i < 20 && !bus.out_valid; i++) step();
    check("t1_out_valid", bus.out_valid, 1'b1);
    check("t1_latency", cyc - c0, MUL_LAT + 1);
    check("t1_out_re", bus.out_re, 32'hC0A00000);
    check("t1_out_im", bus.out_im, 32'h41200000);
    check("t1_out_tag", bus.out_tag, 4'd5);
    drain();

    // T2: 20 requests offered back to back, tags wrapping
    en0 = n_en;
    for (int i = 0; i < 20; i++) begin
      rand_req(4'(i % 16));
      offer();
    end
    drain();
    check("t2_enables", n_en - en0, 20);

    // T3: consumer stalled, 12 offered, only DEPTH issue
    en0 = n_en;
    pop0 = n_pop;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_req(4'(i));
      offer();
    end
    rand_req(4'(DEPTH));
    repeat (20) step();
    check("t3_issued_stalled", n_en - en0, DEPTH);
    check("t3_in_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    offer();
    for (int i = DEPTH + 1; i < 12; i++) begin
      rand_req(4'(i));
      offer();
    end
    drain();
    check("t3_issued_total", n_en - en0, 12);
    check("t3_popped_total", n_pop - pop0, 12);

    // T4: fill, then random consumer with a continuously offered stream
    en0 = n_en;
    pop0 = n_pop;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rand_req(4'($urandom_range(0, 15)));
      offer();
    end
    rand_req(4'($urandom_range(0, 15)));
    for (int i = 0; i < 50; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_iss) rand_req(4'($urandom_range(0, 15)));
    end
    drain();
    check("t4_no_loss", n_pop - pop0, n_en - en0);

    // T5: reset with 3 in flight and 2 buffered
    pop0 = n_pop;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_req(4'(i + 8));
      offer();
    end
    repeat (4) step();
    check("t5_pre_inflight", inflight, 3);
    check("t5_pre_out_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_out_valid", bus.out_valid, 1'b0);
    check("t5_inflight", inflight, 0);
    bus.out_ready = 1'b1;
    repeat (15) step();
    check("t5_no_stale", n_pop - pop0, 0);

    // T6: spurious mul_valid with nothing in flight
    spur = 1'b1;
    step();
    spur = 1'b0;
    check("t6_err_set", err_spurious, 1'b1);
    repeat (5) step();
    check("t6_err_sticky", err_spurious, 1'b1);
    check("t6_fifo_empty", bus.out_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_err_cleared", err_spurious, 1'b0);

    // Post-reset sanity: traffic still flows
    rand_req(4'd3);
    offer();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
